btn_event_ctrl: RTL and testbench
=================================

# btn_event_ctrl

Event controller for the debounced pushbutton and slider-switch levels. It detects enabled rising and falling edges and arbitrates simultaneous edges into one event per cycle. Each event is tagged with a tick-based timestamp and buffered in a small FIFO that the SweRVolf GPIO/CPU side drains through a valid/ready pop port. A level interrupt flags pending events and lost events.

## Interface
- NUM_IN, 22: number of debounced inputs; bits 0-5 are pushbuttons, bits 6-21 are switches 0-15.
- FIFO_DEPTH, 8: event FIFO entries; must be a power of 2, ≥2.
- TS_WIDTH, 16: timestamp counter width.
- IDX_W, 5: index field width; must satisfy 2^IDX_W ≥ NUM_IN.
- EVT_W, TS_WIDTH+1+IDX_W: event word width, 22 by default.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- db_in  in  NUM_IN  debounced levels, synchronous to clk.
- rise_en  in  NUM_IN  per-input rising-edge event enable.
- fall_en  in  NUM_IN  per-input falling-edge event enable.
- tick  in  1  one-cycle timestamp strobe, nominally 1 kHz.
- evt_valid  out  1  FIFO head is valid.
- evt_data  out  EVT_W  head event word, laid out as {ts, edge, idx}; edge=1 means rise.
- evt_ready  in  1  consumer pops the head when evt_valid && evt_ready.
- evt_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky flag; one or more events were lost.
- ovf_clr  in  1  clears overflow.
- irq  out  1  registered value of (evt_count≠0) | overflow.

## Operation
- Reset values: all outputs are 0. The FIFO is empty, the pending vectors are 0, ts=0, and armed=0.
- Arming: the first clock after reset loads prev←db_in, sets armed=1, and generates no edges. After that, prev←db_in every cycle.
- Detect: rise_hit = armed & db_in & ~prev & rise_en. fall_hit = armed & ~db_in & prev & fall_en.
- Pending update: pend_rise |= rise_hit and pend_fall |= fall_hit.
  - If a hit lands on a bit that is already pending and not being serviced this cycle, the two edges merge and overflow is set.
  - Clearing rise_en or fall_en does not cancel a bit that is already pending.
- Arbitration: fixed priority, lowest index first. For the same index, rise goes before fall.
  - One event per cycle is pushed when the FIFO accepts.
  - The serviced pending bit clears in the same edge as the push.
  - A hit arriving on the bit being serviced in that same edge re-sets it and does not count as a merge.
- Event word: idx is the input number, edge is the pending type, and ts is the counter value at the push edge.
- FIFO accepts a push when evt_count<FIFO_DEPTH, or when a pop occurs in the same cycle (push and pop together when full is legal). Otherwise arbitration stalls, pending bits hold, and new hits on held bits set overflow.
- FIFO reads are first-word-fall-through: evt_data is the head whenever evt_valid=1. evt_data is don't-care when the FIFO is empty.
- A pop on an empty FIFO is ignored.
- Timestamp: ts increments on tick and wraps from 2^TS_WIDTH−1 to 0. A push and a tick in the same cycle record the pre-increment value.
- overflow is set by any loss and cleared by ovf_clr. If set and clear occur in the same cycle, set wins.

## Timing
- A db_in change, visible before edge k, sets pending at edge k.
- The push happens at edge k+1 if this input wins arbitration and the FIFO has room. evt_valid therefore rises 2 cycles after the input change.
- irq follows evt_valid/overflow one cycle later.
- Worst-case service latency with an empty FIFO is 2·NUM_IN cycles, far below one tick period.
- A pop at edge p updates evt_valid, evt_data and evt_count after edge p.
- Asserting rst_n low mid-operation immediately drops the FIFO contents, pending bits, ts and all outputs to their reset values. armed is also cleared, so there are no spurious edges after release.

## Structure
- Package btn_evt_pkg holds:
  - IDX_W, TS_WIDTH and EVT_W;
  - EDGE_RISE=1'b1 and EDGE_FALL=1'b0;
  - the packed event struct {ts, edge, idx};
  - the button/switch base indices, PB_BASE=0 and SW_BASE=6.
- Sub-module btn_evt_fifo: synchronous FWFT FIFO with parameters DEPTH and WIDTH. It has ports push, wdata, full, pop, rdata, empty and count, and a pointer-wrap extra bit.
- The arbiter is a priority encoder over {pend_fall, pend_rise}, with rise interleaved ahead of fall per index.

## Test plan
- Reset with db_in=22'h3FFFFF → no events after release. Then set db_in[3]=0 with fall_en[3]=1 → one event {ts, 0, 3} with evt_valid 2 cycles later and irq 1 cycle after that.
- Set bits 0, 7 and 21 rising on the same cycle, all enabled → events appear in idx order 0, 7, 21 on consecutive cycles, and evt_count=3.
- Hold evt_ready=0 and generate 9 distinct enabled edges → evt_count saturates at 8 and one stays pending. Then toggle the pending bit again → overflow=1. Pop once → the held event is pushed.
- FIFO full: assert evt_ready and a new edge on the same cycle → evt_count stays at 8, data order is preserved, and overflow=0.
- Drive 65536 ticks → ts wraps to 0. Push and tick on the same cycle → the event records the old ts value.
- Pulse rst_n low with 4 events queued and bits pending → everything clears asynchronously, and no event appears on release even with db_in≠0.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared widths, edge encodings and the event word layout for the button/switch event path.
package btn_evt_pkg;

  localparam int IDX_W    = 5;
  localparam int TS_WIDTH = 16;
  localparam int EVT_W    = TS_WIDTH + 1 + IDX_W;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  // Input numbering: pushbuttons occupy the low bits, slide switches follow.
  localparam int PB_BASE = 0;
  localparam int SW_BASE = 6;

  // "edge" is a reserved word, hence edge_dir.
  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic                edge_dir;
    logic [IDX_W-1:0]    idx;
  } evt_t;

endpackage

// File: rtl/btn_evt_fifo.sv
// First-word-fall-through event FIFO; pointers carry one extra wrap bit so full/empty need no flag.
module btn_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 22
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  output logic                       full,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_pop;
  logic             do_push;

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == ($clog2(DEPTH+1))'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A write into a full FIFO is legal when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  // Storage array; contents are only observed through valid pointers, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  // Read/write pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Edge detector, pending-bit arbiter and timestamped event queue for debounced buttons/switches.
module btn_event_ctrl #(
  parameter int NUM_IN     = 22,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = btn_evt_pkg::TS_WIDTH,
  parameter int IDX_W      = btn_evt_pkg::IDX_W,
  parameter int EVT_W      = TS_WIDTH + 1 + IDX_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_IN-1:0]               db_in,
  input  logic [NUM_IN-1:0]               rise_en,
  input  logic [NUM_IN-1:0]               fall_en,
  input  logic                            tick,
  output logic                            evt_valid,
  output logic [EVT_W-1:0]                evt_data,
  input  logic                            evt_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] evt_count,
  output logic                            overflow,
  input  logic                            ovf_clr,
  output logic                            irq
);

  import btn_evt_pkg::*;

  logic                armed;
  logic [NUM_IN-1:0]   prev;
  logic [NUM_IN-1:0]   pend_rise;
  logic [NUM_IN-1:0]   pend_fall;
  logic [NUM_IN-1:0]   rise_hit;
  logic [NUM_IN-1:0]   fall_hit;
  logic [NUM_IN-1:0]   sel_onehot;
  logic [NUM_IN-1:0]   svc_rise;
  logic [NUM_IN-1:0]   svc_fall;
  logic [TS_WIDTH-1:0] ts;
  logic                sel_valid;
  logic                sel_edge;
  logic [IDX_W-1:0]    sel_idx;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                loss;
  logic [EVT_W-1:0]    fifo_rdata;

  // Edges only count once prev holds a real sample, so release from reset never fires events.
  assign rise_hit = {NUM_IN{armed}} & db_in & ~prev & rise_en;
  assign fall_hit = {NUM_IN{armed}} & ~db_in & prev & fall_en;

  // Lowest index wins; within an index the rise is taken ahead of the fall.
  always_comb begin
    sel_valid  = 1'b0;
    sel_edge   = EDGE_FALL;
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (pend_fall[i]) begin
        sel_valid  = 1'b1;
        sel_edge   = EDGE_FALL;
        sel_idx    = IDX_W'(i);
        sel_onehot = NUM_IN'(1) << i;
      end
      if (pend_rise[i]) begin
        sel_valid  = 1'b1;
        sel_edge   = EDGE_RISE;
        sel_idx    = IDX_W'(i);
        sel_onehot = NUM_IN'(1) << i;
      end
    end
  end

  assign push     = sel_valid & (~fifo_full | (evt_ready & ~fifo_empty));
  assign svc_rise = (push && sel_edge == EDGE_RISE) ? sel_onehot : '0;
  assign svc_fall = (push && sel_edge == EDGE_FALL) ? sel_onehot : '0;
  // A hit on a bit that stays pending merges two edges into one event.
  assign loss     = (|(rise_hit & pend_rise & ~svc_rise)) | (|(fall_hit & pend_fall & ~svc_fall));

  // Arming, level history and pending-edge bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      prev      <= '0;
      pend_rise <= '0;
      pend_fall <= '0;
    end else begin
      armed     <= 1'b1;
      prev      <= db_in;
      pend_rise <= (pend_rise & ~svc_rise) | rise_hit;
      pend_fall <= (pend_fall & ~svc_fall) | fall_hit;
    end
  end

  // Free-running tick counter used as the event timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else if (tick) ts <= ts + 1'b1;
  end

  // Sticky loss flag (set beats clear) and interrupt level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (loss) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      irq <= (evt_count != '0) | overflow;
    end
  end

  btn_evt_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EVT_W)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata({ts, sel_edge, sel_idx}),
    .full (fifo_full),
    .pop  (evt_ready),
    .rdata(fifo_rdata),
    .empty(fifo_empty),
    .count(evt_count)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_data  = fifo_empty ? '0 : fifo_rdata;

endmodule

// File: tb/tb_btn_event_ctrl.sv
module tb_btn_event_ctrl;
  import btn_evt_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [21:0] db_in, rise_en, fall_en;
  logic        tick, evt_ready, ovf_clr;
  logic        evt_valid, overflow, irq;
  logic [21:0] evt_data;
  logic [3:0]  evt_count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [21:0] exp_q[$];

  btn_event_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .db_in    (db_in),
    .rise_en  (rise_en),
    .fall_en  (fall_en),
    .tick     (tick),
    .evt_valid(evt_valid),
    .evt_data (evt_data),
    .evt_ready(evt_ready),
    .evt_count(evt_count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [21:0] mk(input logic [15:0] ts, input logic e, input int idx);
    evt_t ev;
    ev.ts       = ts;
    ev.edge_dir = e;
    ev.idx      = IDX_W'(idx);
    return ev;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 40;
    evt_ready = 1'b1;
    while (evt_valid && budget > 0) begin
      step();
      budget--;
    end
    evt_ready = 1'b0;
    chk_eq({tag, "_empty"}, evt_valid, 0);
    chk_eq({tag, "_q"}, exp_q.size(), 0);
  endtask

  // Scoreboard: every pop the DUT will take on the next edge is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) chk_eq("evt_unexpected", exp_q.size(), 1);
      else chk_eq("evt_data", evt_data, exp_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; db_in = 22'h3FFFFF; rise_en = 22'h3FFFFF; fall_en = 22'h3FFFFF;
    tick = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
    #23;
    chk_eq("rst_valid", evt_valid, 0);
    chk_eq("rst_count", evt_count, 0);
    chk_eq("rst_ovf", overflow, 0);
    chk_eq("rst_irq", irq, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) step();
    chk_eq("arm_no_evt", evt_count, 0);

    // single falling edge and its latency
    db_in[3] = 1'b0;
    exp_q.push_back(mk(16'h0, EDGE_FALL, 3));
    step();
    chk_eq("lat_k_valid", evt_valid, 0);
    step();
    chk_eq("lat_k1_valid", evt_valid, 1);
    chk_eq("lat_k1_irq", irq, 0);
    chk_eq("lat_k1_data", evt_data, mk(16'h0, EDGE_FALL, 3));
    step();
    chk_eq("lat_k2_irq", irq, 1);
    drain("t1");

    // simultaneous rises leave in index order
    fall_en = '0;
    db_in[0] = 1'b0; db_in[7] = 1'b0; db_in[21] = 1'b0;
    repeat (3) step();
    chk_eq("fall_dis_count", evt_count, 0);
    db_in[0] = 1'b1; db_in[7] = 1'b1; db_in[21] = 1'b1;
    exp_q.push_back(mk(16'h0, EDGE_RISE, 0));
    exp_q.push_back(mk(16'h0, EDGE_RISE, 7));
    exp_q.push_back(mk(16'h0, EDGE_RISE, 21));
    repeat (4) step();
    chk_eq("multi_count", evt_count, 3);
    drain("t2");

    // nine edges into an eight-deep FIFO, then a merge on the held bit
    db_in = '0;
    repeat (3) step();
    chk_eq("quiet_count", evt_count, 0);
    db_in[8:0] = 9'h1FF;
    for (int i = 0; i < 9; i++) exp_q.push_back(mk(16'h0, EDGE_RISE, i));
    repeat (12) step();
    chk_eq("sat_count", evt_count, 8);
    chk_eq("sat_ovf", overflow, 0);
    db_in[8] = 1'b0;
    step();
    db_in[8] = 1'b1;
    step();
    chk_eq("merge_ovf", overflow, 1);
    step();
    chk_eq("merge_irq", irq, 1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk_eq("refill_count", evt_count, 8);
    chk_eq("refill_ovf", overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk_eq("ovf_clr", overflow, 0);

    // push and pop together while full
    db_in[9] = 1'b1;
    exp_q.push_back(mk(16'h0, EDGE_RISE, 9));
    repeat (2) step();
    chk_eq("full_hold_count", evt_count, 8);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk_eq("pushpop_count", evt_count, 8);
    chk_eq("pushpop_ovf", overflow, 0);
    drain("t4");

    // timestamp wrap and push coinciding with tick
    tick = 1'b1;
    repeat (65534) step();
    db_in[10] = 1'b1;
    exp_q.push_back(mk(16'hFFFF, EDGE_RISE, 10));
    repeat (2) step();
    tick = 1'b0;
    db_in[11] = 1'b1;
    exp_q.push_back(mk(16'h0, EDGE_RISE, 11));
    repeat (3) step();
    chk_eq("wrap_count", evt_count, 2);
    drain("t5");

    // asynchronous reset with queued and pending events
    db_in[19:12] = 8'hFF;
    for (int i = 12; i < 20; i++) exp_q.push_back(mk(16'h0, EDGE_RISE, i));
    repeat (5) step();
    chk_eq("prerst_count", evt_count, 4);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_valid", evt_valid, 0);
    chk_eq("arst_count", evt_count, 0);
    chk_eq("arst_irq", irq, 0);
    chk_eq("arst_data", evt_data, 0);
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk_eq("rel_valid", evt_valid, 0);
    chk_eq("rel_count", evt_count, 0);
    db_in[20] = 1'b1;
    exp_q.push_back(mk(16'h0, EDGE_RISE, 20));
    repeat (3) step();
    chk_eq("post_rst_valid", evt_valid, 1);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
